// File: rtl/instr_select_pkg.sv
// Shared configuration for the instruction-select stage: address/associativity
// macros, ITLB/ICache entry types, privilege state and the refill FSM states.
// Optional feature macro: ITLB_EXEC_CHECK_EN (exec/user permission checking).
`ifndef VADDR_WIDTH
`define VADDR_WIDTH 32
`endif
`ifndef ITLB_ASSOC
`define ITLB_ASSOC 4
`endif
`ifndef ICACHE_ASSOC
`define ICACHE_ASSOC 4
`endif

package instr_select_pkg;

  localparam int unsigned VADDR_W       = `VADDR_WIDTH;
  localparam int unsigned PAGE_OFFSET_W = 12;
  localparam int unsigned VPN_W         = VADDR_W - PAGE_OFFSET_W;
  localparam int unsigned PPN_W         = 20;
  localparam int unsigned PTAG_W        = PPN_W;
  localparam int unsigned INSTR_W       = 32;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
    logic             exec;
    logic             user;
  } tlb_entry_t;

  typedef struct packed {
    logic              valid;
    logic [PTAG_W-1:0] ptag;
  } icache_tag_entry_t;

  typedef logic [INSTR_W-1:0] icache_data_unit_t;

  typedef enum logic [1:0] {
    PRIV_USER    = 2'd0,
    PRIV_SUPER   = 2'd1,
    PRIV_MACHINE = 2'd3
  } program_state_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPLAY = 2'd3
  } fetch_state_e;

  // Translation plus permissions, carried through the ITLB way mux as one word
  typedef struct packed {
    logic [PPN_W-1:0] ppn;
    logic             exec;
    logic             user;
  } tlb_payload_t;

endpackage

// File: rtl/instr_way_select.sv
// Generic set-associative way lookup: per-way valid/key compare against a
// lookup key, returning a hit flag and the data of the lowest matching way.
module instr_way_select #(
  parameter int unsigned WAYS   = 4,
  parameter int unsigned KEY_W  = 20,
  parameter int unsigned DATA_W = 32
) (
  input  logic [WAYS-1:0]             valid_i,
  input  logic [WAYS-1:0][KEY_W-1:0]  key_i,
  input  logic [WAYS-1:0][DATA_W-1:0] data_i,
  input  logic [KEY_W-1:0]            lookup_i,
  output logic                        hit_o,
  output logic [DATA_W-1:0]           data_o
);

  logic [WAYS-1:0] match;

  // Per-way tag match, gated by the valid bit
  always_comb begin
    match = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      match[w] = valid_i[w] && (key_i[w] == lookup_i);
    end
  end

  // Priority mux: the lowest-numbered matching way supplies the data
  always_comb begin
    logic found;
    found  = 1'b0;
    data_o = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (match[w] && !found) begin
        found  = 1'b1;
        data_o = data_i[w];
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/instr_select.sv
// Fetch instruction select: ITLB + ICache hit detection on the per-way RAM
// read results for i_pc, registered instruction output, and a refill FSM
// (IDLE/REQ/WAIT/REPLAY) that requests ITLB or ICache fills on a miss.
// Optional feature macro: ITLB_EXEC_CHECK_EN -- when defined, fetches from
// pages lacking exec (or user, in user mode) permission return a fault.
module instr_select
  import instr_select_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [`VADDR_WIDTH-1:0]  i_pc,
  input  tlb_entry_t               i_itlb       [`ITLB_ASSOC],
  input  icache_tag_entry_t        i_icache_tag [`ICACHE_ASSOC],
  input  icache_data_unit_t        i_icache_data[`ICACHE_ASSOC],
  input  program_state_t           i_pstate,
  input  logic                     i_flush,
  output logic                     o_stall,
  output logic                     o_valid,
  output logic [`VADDR_WIDTH-1:0]  o_pc,
  output icache_data_unit_t        o_instr,
  output logic                     o_fault,
  output logic                     o_refill_req,
  output logic                     o_refill_itlb,
  output logic [`VADDR_WIDTH-1:0]  o_refill_vaddr,
  input  logic                     i_refill_ack,
  input  logic                     i_refill_done
);

  localparam int unsigned PAY_W = $bits(tlb_payload_t);

  // ---- way lookup plumbing ----
  logic [`ITLB_ASSOC-1:0]                tlb_valid;
  logic [`ITLB_ASSOC-1:0][VPN_W-1:0]     tlb_vpn;
  logic [`ITLB_ASSOC-1:0][PAY_W-1:0]     tlb_pay;
  logic [`ICACHE_ASSOC-1:0]              ic_valid;
  logic [`ICACHE_ASSOC-1:0][PTAG_W-1:0]  ic_tag;
  logic [`ICACHE_ASSOC-1:0][INSTR_W-1:0] ic_data;

  logic              itlb_hit;
  logic [PAY_W-1:0]  tlb_sel_raw;
  tlb_payload_t      tlb_sel;
  logic              ic_raw_hit;
  logic              ic_hit;
  icache_data_unit_t ic_sel;
  logic              perm_fault;
  logic              fetch_hit;

  // Flatten the per-way RAM read structs into packed lookup vectors
  always_comb begin
    tlb_valid = '0;
    tlb_vpn   = '0;
    tlb_pay   = '0;
    ic_valid  = '0;
    ic_tag    = '0;
    ic_data   = '0;
    for (int unsigned w = 0; w < `ITLB_ASSOC; w++) begin
      tlb_valid[w] = i_itlb[w].valid;
      tlb_vpn[w]   = i_itlb[w].vpn;
      tlb_pay[w]   = {i_itlb[w].ppn, i_itlb[w].exec, i_itlb[w].user};
    end
    for (int unsigned w = 0; w < `ICACHE_ASSOC; w++) begin
      ic_valid[w] = i_icache_tag[w].valid;
      ic_tag[w]   = i_icache_tag[w].ptag;
      ic_data[w]  = i_icache_data[w];
    end
  end

  instr_way_select #(
    .WAYS  (`ITLB_ASSOC),
    .KEY_W (VPN_W),
    .DATA_W(PAY_W)
  ) u_itlb_sel (
    .valid_i (tlb_valid),
    .key_i   (tlb_vpn),
    .data_i  (tlb_pay),
    .lookup_i(i_pc[VADDR_W-1:PAGE_OFFSET_W]),
    .hit_o   (itlb_hit),
    .data_o  (tlb_sel_raw)
  );

  assign tlb_sel = tlb_sel_raw;

  instr_way_select #(
    .WAYS  (`ICACHE_ASSOC),
    .KEY_W (PTAG_W),
    .DATA_W(INSTR_W)
  ) u_icache_sel (
    .valid_i (ic_valid),
    .key_i   (ic_tag),
    .data_i  (ic_data),
    .lookup_i(tlb_sel.ppn),
    .hit_o   (ic_raw_hit),
    .data_o  (ic_sel)
  );

  // The physical tag is only meaningful when the ITLB translated the PC
  assign ic_hit = itlb_hit && ic_raw_hit;

`ifdef ITLB_EXEC_CHECK_EN
  assign perm_fault = itlb_hit &&
                      (!tlb_sel.exec || (!tlb_sel.user && (i_pstate == PRIV_USER)));
`else
  logic perm_unused;
  assign perm_fault  = 1'b0;
  assign perm_unused = ^{i_pstate, tlb_sel.exec, tlb_sel.user};
`endif

  // A permission fault completes the fetch without touching the ICache
  assign fetch_hit = itlb_hit && (perm_fault || ic_hit);

  // ---- FSM and output registers ----
  fetch_state_e          state_q, state_d;
  logic                  valid_q, valid_d;
  logic [VADDR_W-1:0]    pc_q, pc_d;
  icache_data_unit_t     instr_q, instr_d;
  logic                  fault_d;
  logic                  refill_itlb_q, refill_itlb_d;
  logic [VADDR_W-1:0]    refill_vaddr_q, refill_vaddr_d;
  logic                  aborted_q, aborted_d;

  // Next-state logic: hit capture in IDLE, refill handshake, replay, flush abort
  always_comb begin
    state_d        = state_q;
    valid_d        = 1'b0;
    pc_d           = pc_q;
    instr_d        = instr_q;
    fault_d        = 1'b0;
    refill_itlb_d  = refill_itlb_q;
    refill_vaddr_d = refill_vaddr_q;
    aborted_d      = aborted_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_flush) begin
          state_d = ST_IDLE;
        end else if (fetch_hit) begin
          valid_d = 1'b1;
          pc_d    = i_pc;
          instr_d = ic_sel;
          fault_d = perm_fault;
        end else begin
          state_d        = ST_REQ;
          refill_itlb_d  = !itlb_hit;
          refill_vaddr_d = i_pc;
        end
      end
      ST_REQ: begin
        if (i_flush) aborted_d = 1'b1;
        if (i_refill_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An aborted fill still has to finish, but is not replayed
        if (i_refill_done) begin
          state_d   = (aborted_q || i_flush) ? ST_IDLE : ST_REPLAY;
          aborted_d = 1'b0;
        end else if (i_flush) begin
          aborted_d = 1'b1;
        end
      end
      ST_REPLAY: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      valid_q        <= 1'b0;
      pc_q           <= '0;
      instr_q        <= '0;
      refill_itlb_q  <= 1'b0;
      refill_vaddr_q <= '0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      refill_itlb_q  <= refill_itlb_d;
      refill_vaddr_q <= refill_vaddr_d;
      aborted_q      <= aborted_d;
    end
  end

`ifdef ITLB_EXEC_CHECK_EN
  logic fault_q;

  // Registered fetch fault, qualified by o_valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign o_fault = fault_q;
`else
  logic fault_unused;
  assign fault_unused = fault_d;
  assign o_fault      = 1'b0;
`endif

  assign o_stall        = (state_q != ST_IDLE) || !fetch_hit;
  assign o_valid        = valid_q;
  assign o_pc           = pc_q;
  assign o_instr        = instr_q;
  assign o_refill_req   = (state_q == ST_REQ);
  assign o_refill_itlb  = refill_itlb_q;
  assign o_refill_vaddr = refill_vaddr_q;

endmodule

// File: tb/tb_instr_select.sv
// Bench for instr_select: the bench owns the ITLB/ICache contents, a fixed
// page table and a memory image; expected fetch results come from those.
module tb_instr_select;
  import instr_select_pkg::*;

  localparam int unsigned NSETS = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       pc_in;
  tlb_entry_t        itlb  [`ITLB_ASSOC];
  icache_tag_entry_t ictag [`ICACHE_ASSOC];
  icache_data_unit_t icdata[`ICACHE_ASSOC];
  program_state_t    pstate;
  logic              flush, ack, done;
  logic              o_stall, o_valid, o_fault, o_refill_req, o_refill_itlb;
  logic [31:0]       o_pc, o_refill_vaddr;
  icache_data_unit_t o_instr;

  instr_select dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_pc          (pc_in),
    .i_itlb        (itlb),
    .i_icache_tag  (ictag),
    .i_icache_data (icdata),
    .i_pstate      (pstate),
    .i_flush       (flush),
    .o_stall       (o_stall),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_fault       (o_fault),
    .o_refill_req  (o_refill_req),
    .o_refill_itlb (o_refill_itlb),
    .o_refill_vaddr(o_refill_vaddr),
    .i_refill_ack  (ack),
    .i_refill_done (done)
  );

  // ---- reference world ----
  tlb_entry_t  m_tlb[`ITLB_ASSOC];
  logic        m_cv [NSETS][`ICACHE_ASSOC];
  logic [19:0] m_ct [NSETS][`ICACHE_ASSOC];

  logic [31:0]    pc;
  program_state_t ps;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;
  exp_t sbq[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [19:0] pt(input logic [19:0] vpn);
    return vpn ^ (vpn << 3) ^ 20'hA5000;
  endfunction
  function automatic logic pg_exec(input logic [19:0] vpn);
    return vpn != 20'd7;
  endfunction
  function automatic logic pg_user(input logic [19:0] vpn);
    return vpn < 20'd6;
  endfunction
  function automatic logic [31:0] pa_of(input logic [31:0] a);
    return {pt(a[31:12]), a[11:0]};
  endfunction
  function automatic logic [31:0] mem(input logic [31:0] pa);
    return (pa * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction
  function automatic logic fault_of(input logic [31:0] a, input program_state_t p);
`ifdef ITLB_EXEC_CHECK_EN
    return !pg_exec(a[31:12]) || (!pg_user(a[31:12]) && p == PRIV_USER);
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic model_tlb_hit(input logic [31:0] a);
    for (int w = 0; w < `ITLB_ASSOC; w++)
      if (m_tlb[w].valid && m_tlb[w].vpn == a[31:12]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic model_hit(input logic [31:0] a, input program_state_t p);
    logic [7:0] s;
    if (!model_tlb_hit(a)) return 1'b0;
    if (fault_of(a, p)) return 1'b1;
    s = a[11:4];
    for (int w = 0; w < `ICACHE_ASSOC; w++)
      if (m_cv[s][w] && m_ct[s][w] == pt(a[31:12])) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] rand_target();
    logic [19:0] vpn;
    logic [9:0]  wd;
    vpn = 20'($urandom_range(1, 9));
    wd  = 10'($urandom_range(0, 63));
    return {vpn, wd, 2'b00};
  endfunction
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    if ($urandom_range(0, 3) != 0 && a[11:2] != 10'h3FF) return a + 32'd4;
    return rand_target();
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_rams();
    logic [7:0] s;
    s = pc[11:4];
    pc_in  = pc;
    pstate = ps;
    for (int w = 0; w < `ITLB_ASSOC; w++) itlb[w] = m_tlb[w];
    for (int w = 0; w < `ICACHE_ASSOC; w++) begin
      ictag[w].valid = m_cv[s][w];
      ictag[w].ptag  = m_ct[s][w];
      icdata[w]      = m_cv[s][w] ? mem({m_ct[s][w], pc[11:0]}) : $urandom;
    end
  endtask

  task automatic settle();
    drive_rams();
    #1;
  endtask

  task automatic install(input logic is_itlb, input logic [31:0] va);
    int v;
    logic [7:0] s;
    s = va[11:4];
    if (is_itlb) begin
      v = $urandom_range(0, `ITLB_ASSOC - 1);
      m_tlb[v].valid = 1'b1;
      m_tlb[v].vpn   = va[31:12];
      m_tlb[v].ppn   = pt(va[31:12]);
      m_tlb[v].exec  = pg_exec(va[31:12]);
      m_tlb[v].user  = pg_user(va[31:12]);
    end else begin
      v = $urandom_range(0, `ICACHE_ASSOC - 1);
      m_cv[s][v] = 1'b1;
      m_ct[s][v] = pt(va[31:12]);
    end
  endtask

  // Refill responder: ack after d extra REQ cycles, done on the e-th WAIT cycle.
  // flmode 0: no flush, 1: random flushes, 2: flush on first WAIT cycle.
  task automatic refill(input int d, input int e, input int flmode);
    logic        exp_itlb;
    logic [31:0] exp_va;
    bit          ab;
    exp_itlb = !model_tlb_hit(pc);
    exp_va   = pc;
    ab       = 1'b0;
    for (int k = 0; k <= d; k++) begin
      @(negedge clk);
      ack   = (k == d);
      flush = (flmode == 1) && ($urandom_range(0, 7) == 0);
      if (flush) begin ab = 1'b1; pc = rand_target(); end
      settle();
      chk("refill_req", o_refill_req, 1);
      chk("refill_itlb", o_refill_itlb, exp_itlb);
      chk("refill_vaddr", o_refill_vaddr, exp_va);
      chk("stall_req", o_stall, 1);
    end
    for (int k = 0; k < e; k++) begin
      @(negedge clk);
      ack   = 1'b0;
      flush = (flmode == 2 && k == 0) || (flmode == 1 && $urandom_range(0, 7) == 0);
      if (flush) begin ab = 1'b1; pc = (flmode == 2) ? 32'h1004 : rand_target(); end
      done = (k == e - 1);
      if (done) install(exp_itlb, exp_va);
      settle();
      chk("req_dropped", o_refill_req, 0);
      chk("stall_wait", o_stall, 1);
    end
    if (!ab) begin
      @(negedge clk);
      done  = 1'b0;
      flush = 1'b0;
      settle();
      chk("stall_replay", o_stall, 1);
      chk("req_replay", o_refill_req, 0);
    end
  endtask

  // One fetch cycle in IDLE: a hit is scoreboarded, a miss runs a refill
  task automatic do_cycle(input bit fl, input int d, input int e, input int flmode,
                          input bit advance);
    logic hit;
    exp_t ex;
    @(negedge clk);
    ack   = 1'b0;
    done  = 1'b0;
    flush = fl;
    settle();
    hit = model_hit(pc, ps);
    chk("stall_idle", o_stall, !hit);
    chk("req_idle", o_refill_req, 0);
    if (fl) begin
      if (advance) pc = rand_target();
    end else if (hit) begin
      ex.pc    = pc;
      ex.instr = mem(pa_of(pc));
      ex.fault = fault_of(pc, ps);
      sbq.push_back(ex);
      if (advance) pc = next_pc(pc);
    end else begin
      refill(d, e, flmode);
    end
  endtask

  // Monitor: every presented instruction must match the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && o_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", o_valid, 0);
      end else begin
        e = sbq.pop_front();
        chk("o_pc", o_pc, e.pc);
        chk("o_fault", o_fault, e.fault);
        if (!e.fault) chk("o_instr", o_instr, e.instr);
      end
    end
  end

  initial begin
    for (int w = 0; w < `ITLB_ASSOC; w++) begin
      m_tlb[w].valid = 1'b0;
      m_tlb[w].vpn   = 20'($urandom_range(1, 9));
      m_tlb[w].ppn   = 20'($urandom);
      m_tlb[w].exec  = 1'b1;
      m_tlb[w].user  = 1'b1;
    end
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < `ICACHE_ASSOC; w++) begin
        m_cv[s][w] = 1'b0;
        m_ct[s][w] = 20'($urandom);
      end
    pc = 32'h5000; ps = PRIV_SUPER; flush = 1'b1; ack = 1'b0; done = 1'b0;
    drive_rams();

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_req", o_refill_req, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_vaddr", o_refill_vaddr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted while in REQ drops the request at once
    @(negedge clk);
    flush = 1'b0;
    settle();
    chk("stall_miss_5000", o_stall, 1);
    @(negedge clk);
    settle();
    chk("req_before_reset", o_refill_req, 1);
    chk("vaddr_before_reset", o_refill_vaddr, 32'h5000);
    rst_n = 1'b0;
    #1;
    chk("req_after_reset", o_refill_req, 0);
    chk("vaddr_after_reset", o_refill_vaddr, 0);
    flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Hit on way 1 of both ITLB and ICache at 0x1000
    m_tlb[0].valid = 1'b1; m_tlb[0].vpn = 20'hA; m_tlb[0].ppn = pt(20'hA);
    m_tlb[0].exec  = 1'b1; m_tlb[0].user = 1'b1;
    m_tlb[1].valid = 1'b1; m_tlb[1].vpn = 20'h1; m_tlb[1].ppn = pt(20'h1);
    m_tlb[1].exec  = 1'b1; m_tlb[1].user = 1'b1;
    m_tlb[2].valid = 1'b1; m_tlb[2].vpn = 20'h2; m_tlb[2].ppn = pt(20'h2);
    m_tlb[2].exec  = 1'b1; m_tlb[2].user = 1'b1;
    m_cv[0][0] = 1'b1; m_ct[0][0] = pt(20'hA);
    m_cv[0][1] = 1'b1; m_ct[0][1] = pt(20'h1);
    pc = 32'h1000;
    do_cycle(0, 0, 1, 0, 0);

    // ICache miss at 0x2040: ack after 3 extra cycles, done 5 cycles later
    pc = 32'h2040;
    do_cycle(0, 3, 5, 0, 0);
    do_cycle(0, 0, 1, 0, 0);

    // ITLB miss at 0x3000, then ICache miss, then hit
    pc = 32'h3000;
    do_cycle(0, 1, 2, 0, 0);
    do_cycle(0, 2, 1, 0, 0);
    do_cycle(0, 0, 1, 0, 0);

    // Flush during WAIT: no replay, no instruction, straight back to IDLE
    pc = 32'h4000;
    do_cycle(0, 1, 2, 2, 0);
    do_cycle(0, 2, 2, 0, 0);

`ifdef ITLB_EXEC_CHECK_EN
    // User-mode fetch from a supervisor-only page faults without ICache refill
    ps = PRIV_USER;
    pc = 32'h6000;
    do_cycle(0, 0, 1, 0, 0);
    do_cycle(0, 0, 1, 0, 0);
    ps = PRIV_SUPER;
`endif

    // Randomized fetch stream with random flushes and refill timing
    pc = rand_target();
    for (int n = 0; n < 500; n++) begin
      ps = ($urandom_range(0, 1) != 0) ? PRIV_USER : PRIV_SUPER;
      do_cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3),
               $urandom_range(1, 4), 1, 1);
    end

    // Drain: flushing keeps the DUT from fetching
    @(negedge clk);
    flush = 1'b1;
    ack   = 1'b0;
    done  = 1'b0;
    settle();
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
